fifo_burst_reader: RTL and testbench

//  Read-side companion of the stb/ack FIFO. Drains words from a FIFO output port and packs

---
 rtl/fifo_burst_reader.sv | 151 +++++++++++++++
 tb/tb_fifo_burst_reader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Drains words from a stb/ack FIFO output port and packs them into bursts of up to
//   BURST_LEN words. Each burst is raised as an addressed request (b_req/b_addr/b_len)
//   towards the SDRAM controller. Once granted, the burst is streamed out beat by beat
//   (b_dstb/b_data/b_dack). A partial burst is closed by an explicit flush pulse, or
//   after TIMEOUT idle cycles.
//
// Ports
//   CLK, RST           clock; synchronous active-high reset
//   s_data/s_stb/s_ack FIFO read side; a word moves when s_stb & s_ack
//   flush              pulse that closes a partial burst
//   base_addr/base_load load the next-burst address pointer
//   b_req/b_gnt        burst request handshake
//   b_addr/b_len       burst start address and length, held while b_req
//   b_data/b_dstb/b_dack beat data handshake
module fifo_burst_reader #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 22,
  parameter int TIMEOUT   = 64
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [WIDTH-1:0]             s_data,
  input  logic                         s_stb,
  output logic                         s_ack,
  input  logic                         flush,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic                         base_load,
  output logic                         b_req,
  input  logic                         b_gnt,
  output logic [ADDR_W-1:0]            b_addr,
  output logic [$clog2(BURST_LEN):0]   b_len,
  output logic [WIDTH-1:0]             b_data,
  output logic                         b_dstb,
  input  logic                         b_dack
);

  localparam int LW = $clog2(BURST_LEN) + 1;
  localparam int IW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [LW-1:0]     rd_q, rd_d;
  logic [LW-1:0]     len_q, len_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  mem_q [BURST_LEN];
  logic              xfer;
  logic              go_req;

  always_comb begin
    s_ack       = (state_q == S_FILL) && (cnt_q < LW'(BURST_LEN));
    xfer        = s_stb & s_ack;
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    len_d       = len_q;
    idle_d      = idle_q;
    next_addr_d = next_addr_q;
    addr_d      = addr_q;
    go_req      = 1'b0;

    case (state_q)
      S_FILL: begin
        if (xfer) begin
          cnt_d  = cnt_q + LW'(1);
          idle_d = '0;
        end else if (cnt_q != '0) begin
          idle_d = idle_q + IW'(1);
        end
        // A word accepted together with flush joins the burst; cnt_d already counts it.
        if (cnt_q == LW'(BURST_LEN))
          go_req = 1'b1;
        else if (flush && (cnt_q != '0))
          go_req = 1'b1;
        else if ((cnt_q != '0) && !xfer && (idle_q == IW'(TIMEOUT - 1)))
          go_req = 1'b1;
        if (go_req) begin
          state_d = S_REQ;
          len_d   = cnt_d;
          addr_d  = next_addr_q;
        end
      end
      S_REQ: begin
        if (b_gnt) begin
          state_d = S_SEND;
          rd_d    = '0;
        end
      end
      S_SEND: begin
        if (b_dack) begin
          rd_d = rd_q + LW'(1);
          if (rd_q == len_q - LW'(1)) begin
            state_d     = S_FILL;
            cnt_d       = '0;
            idle_d      = '0;
            next_addr_d = addr_q + ADDR_W'(len_q);
          end
        end
      end
      default: begin
        state_d = S_FILL;
        cnt_d   = '0;
        idle_d  = '0;
      end
    endcase

    // An explicit base load overrides the post-burst address advance.
    if (base_load)
      next_addr_d = base_addr;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_FILL;
      cnt_q       <= '0;
      rd_q        <= '0;
      len_q       <= '0;
      idle_q      <= '0;
      next_addr_q <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      len_q       <= len_d;
      idle_q      <= idle_d;
      next_addr_q <= next_addr_d;
      addr_q      <= addr_d;
    end
  end

  // Word buffer holds data only, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (xfer)
      mem_q[cnt_q[LW-2:0]] <= s_data;
  end

  assign b_req  = (state_q == S_REQ);
  assign b_dstb = (state_q == S_SEND);
  assign b_addr = addr_q;
  assign b_len  = len_q;
  assign b_data = b_dstb ? mem_q[rd_q[LW-2:0]] : '0;

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  s_data = '0;
  logic        s_stb = 1'b0;
  logic        s_ack;
  logic        flush = 1'b0;
  logic [21:0] base_addr = '0;
  logic        base_load = 1'b0;
  logic        b_req;
  logic        b_gnt = 1'b1;
  logic [21:0] b_addr;
  logic [3:0]  b_len;
  logic [7:0]  b_data;
  logic        b_dstb;
  logic        b_dack = 1'b1;

  int errors = 0;
  int checks = 0;

  fifo_burst_reader #(.WIDTH(8), .BURST_LEN(8), .ADDR_W(22), .TIMEOUT(64)) dut (
    .CLK(CLK), .RST(RST), .s_data(s_data), .s_stb(s_stb), .s_ack(s_ack), .flush(flush),
    .base_addr(base_addr), .base_load(base_load), .b_req(b_req), .b_gnt(b_gnt),
    .b_addr(b_addr), .b_len(b_len), .b_data(b_data), .b_dstb(b_dstb), .b_dack(b_dack)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic push8(input logic [7:0] first);
    for (int i = 0; i < 8; i++) begin
      s_data = first + 8'(i);
      s_stb  = 1'b1;
      cyc();
    end
    s_stb = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    cyc();
    cyc();
    RST = 1'b0;
    checks++; if (b_req !== 1'b0) begin errors++; $display("FAIL reset_b_req: got %b want 0", b_req); end
    checks++; if (b_dstb !== 1'b0) begin errors++; $display("FAIL reset_b_dstb: got %b want 0", b_dstb); end
    checks++; if (s_ack !== 1'b1) begin errors++; $display("FAIL reset_s_ack: got %b want 1", s_ack); end
    checks++; if (b_addr !== 22'h0 || b_len !== 4'h0 || b_data !== 8'h0) begin
      errors++; $display("FAIL reset_outputs: addr=%h len=%h data=%h want 0", b_addr, b_len, b_data); end
  endtask

  task automatic test_full_burst();
    logic [7:0] e;
    b_gnt = 1'b1; b_dack = 1'b1;
    base_addr = 22'h100; base_load = 1'b1;
    cyc();
    base_load = 1'b0;
    push8(8'h10);
    checks++; if (s_ack !== 1'b0) begin errors++; $display("FAIL full_s_ack: got %b want 0", s_ack); end
    cyc();
    checks++; if (b_req !== 1'b1 || b_addr !== 22'h100 || b_len !== 4'd8) begin
      errors++; $display("FAIL full_req: req=%b addr=%h len=%0d want 1/100/8", b_req, b_addr, b_len); end
    cyc();
    for (int i = 0; i < 8; i++) begin
      e = 8'h10 + 8'(i);
      checks++; if (b_dstb !== 1'b1 || b_data !== e) begin
        errors++; $display("FAIL full_beat%0d: dstb=%b data=%h want 1/%h", i, b_dstb, b_data, e); end
      cyc();
    end
    checks++; if (b_dstb !== 1'b0 || s_ack !== 1'b1) begin
      errors++; $display("FAIL full_done: dstb=%b s_ack=%b want 0/1", b_dstb, s_ack); end
    s_data = 8'h20; s_stb = 1'b1;
    cyc();
    s_stb = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;
    checks++; if (b_req !== 1'b1 || b_addr !== 22'h108 || b_len !== 4'd1) begin
      errors++; $display("FAIL full_next_addr: req=%b addr=%h len=%0d want 1/108/1", b_req, b_addr, b_len); end
    cyc();
    checks++; if (b_data !== 8'h20) begin errors++; $display("FAIL full_single_beat: got %h want 20", b_data); end
    cyc();
  endtask

  task automatic test_timeout();
    int n;
    logic [7:0] e;
    for (int i = 0; i < 3; i++) begin
      s_data = 8'hA0 + 8'(i); s_stb = 1'b1;
      cyc();
    end
    s_stb = 1'b0;
    n = 0;
    while (b_req !== 1'b1 && n < 200) begin
      cyc();
      n++;
    end
    checks++; if (n !== 64) begin errors++; $display("FAIL timeout_cycles: got %0d want 64", n); end
    checks++; if (b_len !== 4'd3 || b_addr !== 22'h109) begin
      errors++; $display("FAIL timeout_req: len=%0d addr=%h want 3/109", b_len, b_addr); end
    cyc();
    for (int i = 0; i < 3; i++) begin
      e = 8'hA0 + 8'(i);
      checks++; if (b_dstb !== 1'b1 || b_data !== e) begin
        errors++; $display("FAIL timeout_beat%0d: dstb=%b data=%h want 1/%h", i, b_dstb, b_data, e); end
      cyc();
    end
  endtask

  task automatic test_flush();
    logic [7:0] e;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (b_req !== 1'b0 || s_ack !== 1'b1) begin
        errors++; $display("FAIL flush_empty%0d: req=%b s_ack=%b want 0/1", i, b_req, s_ack); end
      cyc();
    end
    for (int i = 0; i < 5; i++) begin
      s_data = 8'h30 + 8'(i); s_stb = 1'b1;
      cyc();
    end
    s_data = 8'h35; s_stb = 1'b1; flush = 1'b1;
    cyc();
    s_stb = 1'b0; flush = 1'b0;
    checks++; if (b_req !== 1'b1 || b_len !== 4'd6 || b_addr !== 22'h10C) begin
      errors++; $display("FAIL flush_req: req=%b len=%0d addr=%h want 1/6/10c", b_req, b_len, b_addr); end
    cyc();
    for (int i = 0; i < 6; i++) begin
      e = 8'h30 + 8'(i);
      checks++; if (b_dstb !== 1'b1 || b_data !== e) begin
        errors++; $display("FAIL flush_beat%0d: dstb=%b data=%h want 1/%h", i, b_dstb, b_data, e); end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    logic [39:0] pat;
    logic [7:0]  e;
    int k;
    int c;
    pat = 40'hA5_3C_96_6B_D9;
    b_gnt = 1'b0;
    push8(8'h50);
    cyc();
    s_data = 8'hEE; s_stb = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checks++; if (b_req !== 1'b1 || b_addr !== 22'h112 || b_len !== 4'd8 || s_ack !== 1'b0 || b_dstb !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: req=%b addr=%h len=%0d s_ack=%b dstb=%b want 1/112/8/0/0",
                           i, b_req, b_addr, b_len, s_ack, b_dstb); end
      cyc();
    end
    b_gnt = 1'b1;
    cyc();
    b_gnt = 1'b0;
    checks++; if (b_req !== 1'b0 || b_dstb !== 1'b1) begin
      errors++; $display("FAIL bp_grant: req=%b dstb=%b want 0/1", b_req, b_dstb); end
    k = 0;
    c = 0;
    while (k < 8 && c < 40) begin
      e = 8'h50 + 8'(k);
      checks++; if (b_dstb !== 1'b1 || b_data !== e || s_ack !== 1'b0) begin
        errors++; $display("FAIL bp_beat%0d: dstb=%b data=%h s_ack=%b want 1/%h/0", k, b_dstb, b_data, s_ack, e); end
      b_dack = pat[c];
      if (b_dack && k == 7) s_stb = 1'b0;
      cyc();
      if (b_dack) k++;
      c++;
    end
    b_dack = 1'b1; b_gnt = 1'b1; s_stb = 1'b0;
    checks++; if (k !== 8 || b_dstb !== 1'b0 || s_ack !== 1'b1) begin
      errors++; $display("FAIL bp_done: beats=%0d dstb=%b s_ack=%b want 8/0/1", k, b_dstb, s_ack); end
  endtask

  task automatic test_wrap();
    logic [7:0] e;
    base_addr = 22'h3FFFFC; base_load = 1'b1;
    cyc();
    base_load = 1'b0;
    push8(8'h60);
    cyc();
    checks++; if (b_addr !== 22'h3FFFFC) begin errors++; $display("FAIL wrap_first: got %h want 3ffffc", b_addr); end
    cyc();
    for (int i = 0; i < 8; i++) cyc();
    push8(8'h70);
    cyc();
    checks++; if (b_req !== 1'b1 || b_addr !== 22'h000004) begin
      errors++; $display("FAIL wrap_addr: req=%b addr=%h want 1/000004", b_req, b_addr); end
    cyc();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin base_addr = 22'h2000; base_load = 1'b1; end
      e = 8'h70 + 8'(i);
      checks++; if (b_data !== e) begin errors++; $display("FAIL wrap_beat%0d: got %h want %h", i, b_data, e); end
      cyc();
      base_load = 1'b0;
    end
    s_data = 8'h7F; s_stb = 1'b1;
    cyc();
    s_stb = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;
    checks++; if (b_req !== 1'b1 || b_addr !== 22'h2000 || b_len !== 4'd1) begin
      errors++; $display("FAIL wrap_base_wins: req=%b addr=%h len=%0d want 1/2000/1", b_req, b_addr, b_len); end
    cyc();
    cyc();
  endtask

  task automatic test_reset_mid();
    push8(8'h80);
    cyc();
    cyc();
    for (int i = 0; i < 3; i++) cyc();
    checks++; if (b_dstb !== 1'b1 || b_data !== 8'h83) begin
      errors++; $display("FAIL rstmid_beat3: dstb=%b data=%h want 1/83", b_dstb, b_data); end
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    checks++; if (b_dstb !== 1'b0 || b_req !== 1'b0 || s_ack !== 1'b1) begin
      errors++; $display("FAIL rstmid_state: dstb=%b req=%b s_ack=%b want 0/0/1", b_dstb, b_req, s_ack); end
    s_data = 8'h99; s_stb = 1'b1;
    cyc();
    s_stb = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;
    checks++; if (b_req !== 1'b1 || b_addr !== 22'h0 || b_len !== 4'd1) begin
      errors++; $display("FAIL rstmid_next: req=%b addr=%h len=%0d want 1/0/1", b_req, b_addr, b_len); end
    cyc();
    checks++; if (b_data !== 8'h99) begin errors++; $display("FAIL rstmid_data: got %h want 99", b_data); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_timeout();
    test_flush();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
